// File: rtl/binary_to_bcd_sevenseg_if.sv
// Conversion request / result bundle between a binary source and the BCD 7-segment converter.
interface binary_to_bcd_sevenseg_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic                  start;
  logic [WIDTH-1:0]      binin;
  logic                  busy;
  logic                  valid;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcdout;
  logic [7*DIGITS-1:0]   segments;

  modport master (
    output start, binin,
    input  busy, valid, overflow, bcdout, segments
  );

  modport slave (
    input  start, binin,
    output busy, valid, overflow, bcdout, segments
  );
endinterface

// File: rtl/binary_to_bcd_sevenseg.sv
// Sequential double-dabble binary to BCD converter with registered active-low 7-segment outputs.
// One shift/add-3 step per clock; results land WIDTH+1 cycles after an accepted start.
module binary_to_bcd_sevenseg #(
  parameter int DIGITS        = 4,
  parameter int WIDTH         = 14,
  parameter int BLANK_LEADING = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  binary_to_bcd_sevenseg_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAXV = pow10(DIGITS) - 1;

  generate
    if ((64'd1 << WIDTH) < pow10(DIGITS)) begin : g_width_too_small
      $error("binary_to_bcd_sevenseg: WIDTH too small to cover DIGITS decimal digits");
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Walk from the top digit down; a digit is blanked while every digit above it is zero.
  function automatic logic [SW-1:0] segs_of(input logic [BW-1:0] bcd);
    logic            lead;
    logic [SW-1:0]   s;
    lead = 1'b1;
    s    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && (bcd[4*i +: 4] == 4'd0);
      if ((BLANK_LEADING != 0) && lead && (i > 0))
        s[7*i +: 7] = 7'b1111111;
      else
        s[7*i +: 7] = decode(bcd[4*i +: 4]);
    end
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   shiftreg;
  logic [BW-1:0]      scratch;
  logic [BW-1:0]      adj;
  logic [CW-1:0]      step;
  logic               ovf_pend;
  logic               valid_q;
  logic               ovf_q;
  logic [BW-1:0]      bcd_q;
  logic [SW-1:0]      seg_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (step == CW'(1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftreg <= '0;
      scratch  <= '0;
      step     <= '0;
      ovf_pend <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
      seg_q    <= segs_of('0);
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shiftreg <= bus.binin;
            scratch  <= '0;
            step     <= CW'(WIDTH);
            ovf_pend <= (64'(bus.binin) > MAXV);
          end
        end
        SHIFT: begin
          // The top scratch bit falls off here; out-of-range inputs are already flagged.
          {scratch, shiftreg} <= {adj[BW-2:0], shiftreg, 1'b0};
          step <= step - CW'(1);
        end
        LOAD: begin
          valid_q <= 1'b1;
          if (ovf_pend) begin
            bcd_q <= {DIGITS{4'h9}};
            ovf_q <= 1'b1;
            seg_q <= {DIGITS{7'b0111111}};
          end else begin
            bcd_q <= scratch;
            ovf_q <= 1'b0;
            seg_q <= segs_of(scratch);
          end
        end
        default: ;
      endcase
    end
  end

  // The valid cycle still counts as busy so the next start lines up with valid falling.
  assign bus.busy     = (state != IDLE) || valid_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.bcdout   = bcd_q;
  assign bus.segments = seg_q;
endmodule

// File: tb/tb_binary_to_bcd_sevenseg.sv
// Directed bench for binary_to_bcd_sevenseg: plain and leading-blank instances side by side.
module tb_binary_to_bcd_sevenseg;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  binary_to_bcd_sevenseg_if #(.DIGITS(4), .WIDTH(14)) ifa ();
  binary_to_bcd_sevenseg_if #(.DIGITS(4), .WIDTH(14)) ifb ();

  binary_to_bcd_sevenseg #(.DIGITS(4), .WIDTH(14), .BLANK_LEADING(0)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.slave));
  binary_to_bcd_sevenseg #(.DIGITS(4), .WIDTH(14), .BLANK_LEADING(1)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          blank;
    logic [13:0] val;
    logic [15:0] bcd;
    logic        ovf;
    logic [27:0] seg;
    string       name;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input bit b, input int v, input logic [15:0] bcd,
                         input logic ovf, input logic [27:0] seg, input string n);
    vecs[i].blank = b;
    vecs[i].val   = v[13:0];
    vecs[i].bcd   = bcd;
    vecs[i].ovf   = ovf;
    vecs[i].seg   = seg;
    vecs[i].name  = n;
  endtask

  task automatic drive(input bit sel, input logic s, input logic [13:0] v);
    if (sel) begin ifb.start = s; ifb.binin = v; end
    else     begin ifa.start = s; ifa.binin = v; end
  endtask

  function automatic logic valid_of(input bit sel);
    return sel ? ifb.valid : ifa.valid;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic [15:0] bcd_of(input bit sel);
    return sel ? ifb.bcdout : ifa.bcdout;
  endfunction
  function automatic logic ovf_of(input bit sel);
    return sel ? ifb.overflow : ifa.overflow;
  endfunction
  function automatic logic [27:0] seg_of(input bit sel);
    return sel ? ifb.segments : ifa.segments;
  endfunction

  // lat = edges after the start edge until valid is seen, -1 if it never shows.
  task automatic convert(input bit sel, input logic [13:0] v, output int lat);
    @(negedge clock);
    drive(sel, 1'b1, v);
    @(posedge clock);
    #1 drive(sel, 1'b0, 14'h2AAA);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (valid_of(sel)) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int nvalid;
    int first_c, second_c;
    logic [15:0] cap_bcd, first_bcd, second_bcd;

    set_vec(0, 0, 1234,  16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, "v1234");
    set_vec(1, 0, 9999,  16'h9999, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, "v9999");
    set_vec(2, 0, 10000, 16'h9999, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, "v10000");
    set_vec(3, 0, 0,     16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, "v0");
    set_vec(4, 0, 16383, 16'h9999, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, "vmax");
    set_vec(5, 1, 0,     16'h0000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "b0");
    set_vec(6, 1, 50,    16'h0050, 1'b0, {7'h7F, 7'h7F, 7'h12, 7'h40}, "b50");
    set_vec(7, 1, 1203,  16'h1203, 1'b0, {7'h79, 7'h24, 7'h40, 7'h30}, "b1203");
    set_vec(8, 1, 9,     16'h0009, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h10}, "b9");
    set_vec(9, 1, 10000, 16'h9999, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, "b10000");

    reset = 1'b1;
    drive(0, 1'b0, 14'd0);
    drive(1, 1'b0, 14'd0);
    #12;
    check("rst busy",  ifa.busy, 0);
    check("rst valid", ifa.valid, 0);
    check("rst ovf",   ifa.overflow, 0);
    check("rst bcd",   ifa.bcdout, 0);
    check("rst seg",   ifa.segments, {7'h40, 7'h40, 7'h40, 7'h40});
    check("rst segb",  ifb.segments, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      convert(vecs[i].blank, vecs[i].val, lat);
      check($sformatf("%s lat", vecs[i].name), lat, 15);
      check($sformatf("%s bcd", vecs[i].name), bcd_of(vecs[i].blank), vecs[i].bcd);
      check($sformatf("%s ovf", vecs[i].name), ovf_of(vecs[i].blank), vecs[i].ovf);
      check($sformatf("%s seg", vecs[i].name), seg_of(vecs[i].blank), vecs[i].seg);
      @(posedge clock);
      #1;
      check($sformatf("%s vfall", vecs[i].name), valid_of(vecs[i].blank), 0);
      check($sformatf("%s bfall", vecs[i].name), busy_of(vecs[i].blank), 0);
    end

    // Second start arrives mid-conversion and must be dropped.
    @(negedge clock);
    drive(0, 1'b1, 14'd5678);
    @(posedge clock);
    #1 drive(0, 1'b0, 14'd0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    drive(0, 1'b1, 14'd1);
    @(posedge clock);
    #1 drive(0, 1'b0, 14'd0);
    nvalid  = 0;
    cap_bcd = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (ifa.valid) begin
        nvalid++;
        cap_bcd = ifa.bcdout;
      end
    end
    check("ign nvalid", nvalid, 1);
    check("ign bcd", cap_bcd, 16'h5678);

    // Start held high: back-to-back conversions every WIDTH+2 cycles.
    @(negedge clock);
    drive(0, 1'b1, 14'd7);
    @(posedge clock);
    #1 ifa.binin = 14'd8;
    first_c = -1; second_c = -1;
    first_bcd = '0; second_bcd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (ifa.valid) begin
        if (first_c < 0) begin
          first_c = c; first_bcd = ifa.bcdout;
        end else begin
          second_c = c; second_bcd = ifa.bcdout;
          drive(0, 1'b0, 14'd0);
          break;
        end
      end
    end
    drive(0, 1'b0, 14'd0);
    check("b2b first lat",  first_c, 15);
    check("b2b first bcd",  first_bcd, 16'h0007);
    check("b2b second lat", second_c, 31);
    check("b2b second bcd", second_bcd, 16'h0008);

    // Reset mid-SHIFT aborts the conversion immediately.
    @(negedge clock);
    drive(0, 1'b1, 14'd4321);
    @(posedge clock);
    #1 drive(0, 1'b0, 14'd0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid busy",  ifa.busy, 0);
    check("mid valid", ifa.valid, 0);
    check("mid bcd",   ifa.bcdout, 0);
    check("mid ovf",   ifa.overflow, 0);
    check("mid seg",   ifa.segments, {7'h40, 7'h40, 7'h40, 7'h40});
    @(negedge clock);
    reset = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock);
      #1;
      if (ifa.valid) nvalid++;
    end
    check("mid novalid", nvalid, 0);
    convert(0, 14'd42, lat);
    check("post lat", lat, 15);
    check("post bcd", ifa.bcdout, 16'h0042);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
